// File: rtl/frame_pkg.sv
// Shared types and byte constants for the frame-load sequencer.
package frame_pkg;

  typedef enum logic [1:0] {StIdle, StSync, StLoad, StResp} state_e;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: counts while run is high, flags expiry at TIMEOUT_CYC-1.
module rx_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic sclk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A byte arriving in the expiry cycle clears the timer and suppresses expiry.
  assign expired = run && !clr && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_load_ctrl.sv
// Frames the UART byte stream into one image, writes it to frame RAM and
// answers with ACK on completion or NAK on an inter-byte timeout.
module frame_load_ctrl
  import frame_pkg::*;
#(
  parameter int unsigned IMG_W       = 100,
  parameter int unsigned IMG_H       = 100,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              rx_flag,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              disp_en,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic              tx_req,
  output logic [7:0]        tx_data
);

  localparam int unsigned NPix = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NPix - 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              disp_en_q, disp_en_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic              tx_req_q, tx_req_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic timeout;
  logic last_pix;

  rx_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .sclk    (sclk),
    .rst     (rst),
    .clr     (rx_flag),
    .run     ((state_q == StSync) || (state_q == StLoad)),
    .expired (timeout)
  );

  assign last_pix = (pix_cnt_q == LastAddr);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (rx_flag && (rx_data == HDR0)) state_d = StSync;
      StSync: begin
        if (rx_flag) begin
          if (rx_data == HDR1)      state_d = StLoad;
          else if (rx_data != HDR0) state_d = StIdle;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        if (rx_flag) begin
          if (last_pix) state_d = StResp;
        end else if (timeout) begin
          state_d = StResp;
        end
      end
      StResp: if (!tx_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    disp_en_d    = disp_en_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    tx_req_d     = 1'b0;
    tx_data_d    = tx_data_q;
    unique case (state_q)
      StSync: begin
        if (rx_flag && (rx_data == HDR1)) begin
          pix_cnt_d = '0;
          disp_en_d = 1'b0;
        end
      end
      StLoad: begin
        if (rx_flag) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_cnt_q;
          wr_data_d = rx_data;
          if (last_pix) begin
            frame_done_d = 1'b1;
            disp_en_d    = 1'b1;
            tx_data_d    = ACK;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end else if (timeout) begin
          err_d     = 1'b1;
          tx_data_d = NAK;
        end
      end
      StResp: if (!tx_busy) tx_req_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      pix_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      disp_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      disp_en_q    <= disp_en_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign disp_en    = disp_en_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Scoreboard bench for frame_load_ctrl with a 4x2 image and a short gap timeout.
module tb_frame_load_ctrl;

  localparam int unsigned ImgW  = 4;
  localparam int unsigned ImgH  = 2;
  localparam int unsigned AddrW = 3;
  localparam int unsigned ToCyc = 40;
  localparam int unsigned NPix  = ImgW * ImgH;

  logic             sclk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_flag = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             tx_busy = 1'b0;
  logic             wr_en;
  logic [AddrW-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             disp_en;
  logic             busy;
  logic             frame_done;
  logic             err;
  logic             tx_req;
  logic [7:0]       tx_data;

  frame_load_ctrl #(
    .IMG_W       (ImgW),
    .IMG_H       (ImgH),
    .ADDR_W      (AddrW),
    .TIMEOUT_CYC (ToCyc)
  ) dut (
    .sclk       (sclk),
    .rst        (rst),
    .rx_flag    (rx_flag),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_en    (disp_en),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .tx_req     (tx_req),
    .tx_data    (tx_data)
  );

  always #5 sclk = ~sclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_tx_q[$];
  int exp_pix  = 0;
  int exp_done = 0;
  int exp_err  = 0;
  int n_done   = 0;
  int n_err    = 0;
  int last_wr_cyc = 0;
  int fall_cyc    = 0;
  bit fall_chk    = 1'b0;
  bit prev_busy   = 1'b0;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard whenever the DUT produces a write or response.
  always @(negedge sclk) begin
    if (!rst) begin
      if (wr_en) begin
        check_eq("wr_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) begin
          check_eq("wr_addr", wr_addr, exp_addr_q.pop_front());
          check_eq("wr_data", wr_data, exp_data_q.pop_front());
        end
        last_wr_cyc = cyc;
      end
      if (frame_done) begin
        n_done++;
        check_eq("done_with_last_wr", {wr_en, wr_addr}, {1'b1, 3'(NPix - 1)});
        check_eq("done_disp_en", disp_en, 1);
      end
      if (err) begin
        n_err++;
        check_eq("err_disp_en", disp_en, 0);
        check_eq("err_tx_data", tx_data, 8'h15);
        check_eq("err_latency", cyc - last_wr_cyc, ToCyc);
      end
      if (tx_req) begin
        check_eq("tx_busy_prev", prev_busy, 0);
        check_eq("tx_expected", exp_tx_q.size() != 0, 1);
        if (exp_tx_q.size() != 0) check_eq("tx_data", tx_data, exp_tx_q.pop_front());
        if (fall_chk) begin
          check_eq("tx_after_busy_fall", cyc - fall_cyc, 1);
          fall_chk = 1'b0;
        end
      end
      prev_busy = tx_busy;
    end
  end

  // Entered and left at 1 time unit after a rising edge; strobes are 2 cycles apart.
  task automatic send_byte(input logic [7:0] b);
    rx_flag = 1'b1;
    rx_data = b;
    @(posedge sclk);
    #1 rx_flag = 1'b0;
    @(posedge sclk);
    #1;
  endtask

  task automatic send_hdr();
    send_byte(8'h55);
    send_byte(8'hAA);
    exp_pix = 0;
  endtask

  task automatic send_pix(input logic [7:0] b);
    exp_addr_q.push_back(exp_pix);
    exp_data_q.push_back(int'(b));
    exp_pix++;
    send_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] base);
    send_hdr();
    for (int i = 0; i < NPix; i++) send_pix(base + 8'(i));
    exp_tx_q.push_back(8'h06);
    exp_done++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_wr_q_empty"}, exp_addr_q.size(), 0);
    check_eq({tag, "_tx_q_empty"}, exp_tx_q.size(), 0);
    check_eq({tag, "_done_cnt"}, n_done, exp_done);
    check_eq({tag, "_err_cnt"}, n_err, exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {wr_en, disp_en, busy, frame_done, err, tx_req}, 6'b0);
    check_eq({tag, "_wr_addr"}, wr_addr, 0);
    check_eq({tag, "_wr_data"}, wr_data, 0);
    check_eq({tag, "_tx_data"}, tx_data, 0);
  endtask

  initial begin
    #3 check_all_zero("reset");
    @(posedge sclk);
    #1 rst = 1'b0;
    idle(2);

    // Nominal frame
    send_frame(8'h10);
    idle(6);
    check_eq("nominal_disp_en", disp_en, 1);
    check_eq("nominal_busy", busy, 0);
    check_drained("nominal");

    // Header recovery: junk and a repeated HDR0 before HDR1
    send_byte(8'h12);
    send_byte(8'h55);
    send_frame(8'h20);
    idle(6);
    check_drained("recovery");
    // Broken header returns to idle; following AA/44 must be ignored
    send_byte(8'h55);
    send_byte(8'h33);
    send_byte(8'hAA);
    send_byte(8'h44);
    idle(4);
    check_eq("badhdr_busy", busy, 0);
    check_eq("badhdr_disp_en", disp_en, 1);
    check_drained("badhdr");
    // Timeout while in SYNC: silent return to idle
    send_byte(8'h55);
    idle(ToCyc + 5);
    check_eq("synctmo_busy", busy, 0);
    send_byte(8'hAA);
    send_byte(8'h44);
    idle(4);
    check_drained("synctmo");

    // Timeout during LOAD
    send_hdr();
    for (int i = 0; i < 3; i++) send_pix(8'h30 + 8'(i));
    exp_tx_q.push_back(8'h15);
    exp_err++;
    idle(ToCyc + 5);
    check_eq("tmo_disp_en", disp_en, 0);
    check_eq("tmo_busy", busy, 0);
    check_drained("tmo");
    send_frame(8'h40);
    idle(6);
    check_drained("after_tmo");

    // TX backpressure
    send_hdr();
    for (int i = 0; i < NPix - 1; i++) send_pix(8'h50 + 8'(i));
    tx_busy = 1'b1;
    send_pix(8'h50 + 8'(NPix - 1));
    exp_tx_q.push_back(8'h06);
    exp_done++;
    idle(48);
    check_eq("bp_tx_held", exp_tx_q.size(), 1);
    check_eq("bp_busy", busy, 1);
    tx_busy  = 1'b0;
    fall_cyc = cyc;
    fall_chk = 1'b1;
    idle(5);
    check_eq("bp_tx_sent", fall_chk, 0);
    check_drained("bp");

    // Reset mid-LOAD after 5 pixels
    send_hdr();
    for (int i = 0; i < 5; i++) send_pix(8'h60 + 8'(i));
    rst = 1'b1;
    #1 check_all_zero("midrst");
    idle(3);
    rst = 1'b0;
    idle(3);
    check_drained("midrst");
    send_frame(8'h70);
    idle(6);
    check_drained("after_rst");

    // Byte arriving in the exact timeout cycle wins
    send_hdr();
    for (int i = 0; i < 3; i++) send_pix(8'h80 + 8'(i));
    repeat (ToCyc - 2) @(posedge sclk);
    #1;
    for (int i = 3; i < NPix; i++) send_pix(8'h80 + 8'(i));
    exp_tx_q.push_back(8'h06);
    exp_done++;
    idle(6);
    check_eq("coinc_disp_en", disp_en, 1);
    check_drained("coinc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
